banked_register_file: RTL and testbench

Parametrised multi-context register file for the core's register stage, generalising the two-bank (OS/program) register bank to BANKS contexts of 2^ADDR_W registers each. It provides three asynchronous read ports, one general write port and a dedicated link-register write for jal. A sequential copy engine transfers a whole bank into another bank, one register per cycle, so context switches need no software save/restore loop.

---
 rtl/regbank_pkg.sv | 22 ++
 rtl/regbank_copy_fsm.sv | 74 +++++++
 rtl/banked_register_file.sv | 129 ++++++++++++
 tb/tb_banked_register_file.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the banked register file: default geometry,
// copy-engine state encoding and the bank-select width helper.
package regbank_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_BANKS    = 2;
  localparam int DEF_LINK_REG = 30;

  // Bank-copy engine states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } copy_state_t;

  // Bank select width: at least one bit even for a single bank
  function automatic int bank_width(input int banks);
    return (banks <= 2) ? 1 : $clog2(banks);
  endfunction

endpackage

// File: rtl/regbank_copy_fsm.sv
// Sequential bank-copy engine: after an accepted request it walks every
// register index once, one per clock, emitting a copy write for each.
module regbank_copy_fsm
  import regbank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BANKS  = DEF_BANKS,
  parameter int BANK_W = bank_width(DEF_BANKS)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_copy_start,
  input  logic [BANK_W-1:0] i_copy_src,
  input  logic [BANK_W-1:0] i_copy_dst,
  output logic              o_copy_busy,
  output logic              o_copy_done,
  output logic              o_copy_we,
  output logic [BANK_W-1:0] o_copy_bank,
  output logic [BANK_W-1:0] o_copy_src,
  output logic [ADDR_W-1:0] o_copy_idx
);

  // One extra bit so the bank count itself is representable
  localparam logic [BANK_W:0] BANK_LIM = BANKS[BANK_W:0];

  copy_state_t       r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [BANK_W-1:0] r_src;
  logic [BANK_W-1:0] r_dst;
  logic              w_req_ok;

  // A request is only honoured when both banks exist
  assign w_req_ok = i_copy_start
                 && ({1'b0, i_copy_src} < BANK_LIM)
                 && ({1'b0, i_copy_dst} < BANK_LIM);

  // Copy sequencing: latch banks, walk idx 0..max, one-cycle DONE
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_src   <= '0;
      r_dst   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_ok) begin
            r_src   <= i_copy_src;
            r_dst   <= i_copy_dst;
            r_idx   <= '0;
            r_state <= COPY;
          end
        end
        COPY: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == {ADDR_W{1'b1}}) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Status and copy-write controls decode straight from state registers
  assign o_copy_busy = (r_state == COPY);
  assign o_copy_done = (r_state == DONE);
  assign o_copy_we   = (r_state == COPY);
  assign o_copy_bank = r_dst;
  assign o_copy_src  = r_src;
  assign o_copy_idx  = r_idx;

endmodule

// File: rtl/banked_register_file.sv
// Multi-context register file: BANKS banks of 2^ADDR_W registers, three
// combinational read ports, one write port, a jal link-register write and
// a whole-bank copy engine.
// Optional feature macro: REGBANK_ZERO_REG_EN (index 0 hardwired to zero).
module banked_register_file
  import regbank_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  ADDR_W   = DEF_ADDR_W,
  parameter int  BANKS    = DEF_BANKS,
  parameter int  LINK_REG = DEF_LINK_REG,
  localparam int BANK_W   = bank_width(BANKS)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_jal,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr_write,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [DATA_W-1:0] i_program_counter,
  input  logic [BANK_W-1:0] i_write_bank,
  input  logic [BANK_W-1:0] i_read_bank,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [ADDR_W-1:0] i_addr2,
  input  logic [ADDR_W-1:0] i_addr3,
  output logic [DATA_W-1:0] o_data1,
  output logic [DATA_W-1:0] o_data2,
  output logic [DATA_W-1:0] o_data3,
  input  logic              i_copy_start,
  input  logic [BANK_W-1:0] i_copy_src,
  input  logic [BANK_W-1:0] i_copy_dst,
  output logic              o_copy_busy,
  output logic              o_copy_done
);

  localparam int              NREGS    = 1 << ADDR_W;
  localparam logic [BANK_W:0] BANK_LIM = BANKS[BANK_W:0];
  localparam logic [ADDR_W-1:0] LINK_IDX = LINK_REG[ADDR_W-1:0];

  // Register storage; contents are deliberately left unreset
  logic [DATA_W-1:0] r_regs [BANKS][NREGS];

  logic              w_copy_we;
  logic [BANK_W-1:0] w_copy_bank;
  logic [BANK_W-1:0] w_copy_src;
  logic [ADDR_W-1:0] w_copy_idx;

  logic              w_wr_bank_ok;
  logic              w_rd_bank_ok;
  logic              w_write_en;
  logic              w_jal_en;
  logic              w_copy_en;
  logic [DATA_W-1:0] w_link_data;

  regbank_copy_fsm #(
    .ADDR_W (ADDR_W),
    .BANKS  (BANKS),
    .BANK_W (BANK_W)
  ) u_copy_fsm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_copy_start (i_copy_start),
    .i_copy_src   (i_copy_src),
    .i_copy_dst   (i_copy_dst),
    .o_copy_busy  (o_copy_busy),
    .o_copy_done  (o_copy_done),
    .o_copy_we    (w_copy_we),
    .o_copy_bank  (w_copy_bank),
    .o_copy_src   (w_copy_src),
    .o_copy_idx   (w_copy_idx)
  );

  assign w_wr_bank_ok = ({1'b0, i_write_bank} < BANK_LIM);
  assign w_rd_bank_ok = ({1'b0, i_read_bank} < BANK_LIM);
  assign w_link_data  = i_program_counter + {{(DATA_W-1){1'b0}}, 1'b1};

`ifdef REGBANK_ZERO_REG_EN
  // Index 0 is a constant zero: drop every write aimed at it
  assign w_write_en = i_write && w_wr_bank_ok && (i_addr_write != '0);
  assign w_jal_en   = i_jal && w_wr_bank_ok && (LINK_IDX != '0);
  assign w_copy_en  = w_copy_we && (w_copy_idx != '0);
`else
  assign w_write_en = i_write && w_wr_bank_ok;
  assign w_jal_en   = i_jal && w_wr_bank_ok;
  assign w_copy_en  = w_copy_we;
`endif

  // Storage update; later assignments override earlier ones to the same
  // entry, so Write beats Jal on LINK_REG and both beat the copy write.
  // The copy source is read before the edge, giving pre-edge semantics.
  always_ff @(posedge i_clock) begin
    if (w_copy_en) begin
      r_regs[w_copy_bank][w_copy_idx] <= r_regs[w_copy_src][w_copy_idx];
    end
    if (w_jal_en) begin
      r_regs[i_write_bank][LINK_IDX] <= w_link_data;
    end
    if (w_write_en) begin
      r_regs[i_write_bank][i_addr_write] <= i_data_in;
    end
  end

  logic [ADDR_W-1:0] w_rd_addr [3];
  logic [DATA_W-1:0] w_rd_data [3];

  assign w_rd_addr[0] = i_addr1;
  assign w_rd_addr[1] = i_addr2;
  assign w_rd_addr[2] = i_addr3;

  // Three identical combinational read muxes; nonexistent banks read 0
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      logic w_zero_hit;
`ifdef REGBANK_ZERO_REG_EN
      assign w_zero_hit = (w_rd_addr[gi] == '0);
`else
      assign w_zero_hit = 1'b0;
`endif
      assign w_rd_data[gi] = (w_rd_bank_ok && !w_zero_hit)
                           ? r_regs[i_read_bank][w_rd_addr[gi]]
                           : '0;
    end
  endgenerate

  assign o_data1 = w_rd_data[0];
  assign o_data2 = w_rd_data[1];
  assign o_data3 = w_rd_data[2];

endmodule

// File: tb/tb_banked_register_file.sv
// Directed testbench for banked_register_file (BANKS = 3 so that
// out-of-range bank values are representable on the 2-bit bank ports).
// Honours REGBANK_ZERO_REG_EN when defined.
module tb_banked_register_file;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NB   = 3;
  localparam int BW   = 2;
  localparam int NR   = 32;
  localparam int LINK = 30;
`ifdef REGBANK_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          jal;
  logic          write;
  logic [AW-1:0] addr_write;
  logic [DW-1:0] data_in;
  logic [DW-1:0] pc;
  logic [BW-1:0] write_bank;
  logic [BW-1:0] read_bank;
  logic [AW-1:0] addr1, addr2, addr3;
  logic [DW-1:0] data1, data2, data3;
  logic          copy_start;
  logic [BW-1:0] copy_src, copy_dst;
  logic          copy_busy, copy_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected register contents, maintained by the bench from its own stimulus
  logic [DW-1:0] m [NB][NR];

  always #5 clk = ~clk;

  banked_register_file #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .BANKS    (NB),
    .LINK_REG (LINK)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_jal             (jal),
    .i_write           (write),
    .i_addr_write      (addr_write),
    .i_data_in         (data_in),
    .i_program_counter (pc),
    .i_write_bank      (write_bank),
    .i_read_bank       (read_bank),
    .i_addr1           (addr1),
    .i_addr2           (addr2),
    .i_addr3           (addr3),
    .o_data1           (data1),
    .o_data2           (data2),
    .o_data3           (data3),
    .i_copy_start      (copy_start),
    .i_copy_src        (copy_src),
    .i_copy_dst        (copy_dst),
    .o_copy_busy       (copy_busy),
    .o_copy_done       (copy_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [BW-1:0] b, input logic [AW-1:0] a);
    if (int'(b) >= NB) return '0;
    if (ZR && a == '0) return '0;
    return m[b][a];
  endfunction

  task automatic wr(input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = 1'b1; write_bank = b; addr_write = a; data_in = d;
    tick();
    write = 1'b0;
    if (int'(b) < NB && !(ZR && a == '0)) m[b][a] = d;
  endtask

  task automatic rd(input string tag, input logic [BW-1:0] b, input logic [AW-1:0] a);
    read_bank = b; addr1 = a;
    #1;
    check(tag, data1, exp_rd(b, a));
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_edge;

    rst = 1'b1; jal = 1'b0; write = 1'b0; addr_write = '0; data_in = '0;
    pc = '0; write_bank = '0; read_bank = '0; addr1 = '0; addr2 = '0; addr3 = '0;
    copy_start = 1'b0; copy_src = '0; copy_dst = '0;

    // Reset state
    tick(); tick();
    check("reset_busy", {31'd0, copy_busy}, 32'd0);
    check("reset_done", {31'd0, copy_done}, 32'd0);
    rst = 1'b0;
    tick();

    // Fill all banks with distinct patterns
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < NR; i++) begin
        if (b == 0)      wr(BW'(b), AW'(i), 32'(i * 3));
        else if (b == 1) wr(BW'(b), AW'(i), 32'h1000 + 32'(i));
        else             wr(BW'(b), AW'(i), 32'h2000 + 32'(i));
      end
    end
    $display("fill: banks 0..2 written");

    // Write then read; same-cycle read still sees the old value
    write = 1'b1; write_bank = 2'd1; addr_write = 5'd5; data_in = 32'hDEADBEEF;
    read_bank = 2'd1; addr1 = 5'd5;
    #1;
    check("same_cycle_old", data1, 32'h1005);
    tick();
    write = 1'b0;
    m[1][5] = 32'hDEADBEEF;
    rd("b1_r5_new", 2'd1, 5'd5);
    rd("b0_r5_untouched", 2'd0, 5'd5);
    $display("write: bank1 reg5 <= 0xdeadbeef");

    // Three ports read independent indices
    read_bank = 2'd2; addr1 = 5'd3; addr2 = 5'd17; addr3 = 5'd31;
    #1;
    check("port1", data1, 32'h2003);
    check("port2", data2, 32'h2011);
    check("port3", data3, 32'h201F);

    // Nonexistent bank reads zero
    rd("bank3_reads_zero", 2'd3, 5'd7);

    // Write to nonexistent bank is dropped
    wr(2'd3, 5'd9, 32'h55);
    rd("ignored_wr_b0", 2'd0, 5'd9);
    rd("ignored_wr_b1", 2'd1, 5'd9);
    rd("ignored_wr_b2", 2'd2, 5'd9);

    // Jal alone
    jal = 1'b1; pc = 32'h100; write_bank = 2'd0;
    tick();
    jal = 1'b0;
    m[0][30] = 32'h101;
    rd("jal_alone", 2'd0, 5'd30);
    $display("jal: pc=0x100 bank0");

    // Jal and Write to the link register: Write wins
    jal = 1'b1; pc = 32'h200;
    wr(2'd0, 5'd30, 32'd7);
    jal = 1'b0;
    rd("jal_write_same", 2'd0, 5'd30);

    // Jal and Write to another register: both land
    jal = 1'b1; pc = 32'h100;
    wr(2'd0, 5'd4, 32'h44);
    jal = 1'b0;
    m[0][30] = 32'h101;
    rd("jal_write_link", 2'd0, 5'd30);
    rd("jal_write_r4", 2'd0, 5'd4);

    // Full copy bank0 -> bank1 with a conflicting write and a rejected restart
    copy_start = 1'b1; copy_src = 2'd0; copy_dst = 2'd1;
    tick();
    copy_start = 1'b0;
    check("copy_busy_start", {31'd0, copy_busy}, 32'd1);
    busy_cnt = 1; done_cnt = 0; done_edge = -1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 11) begin
        write = 1'b1; write_bank = 2'd1; addr_write = 5'd10; data_in = 32'hAA;
      end
      if (e == 5) begin
        copy_start = 1'b1; copy_src = 2'd1; copy_dst = 2'd0;
      end
      tick();
      write = 1'b0; copy_start = 1'b0;
      if (copy_busy) busy_cnt++;
      if (copy_done) begin done_cnt++; done_edge = e; end
    end
    check("copy_busy_cycles", 32'(busy_cnt), 32'd32);
    check("copy_done_pulses", 32'(done_cnt), 32'd1);
    check("copy_done_edge", 32'(done_edge), 32'd32);
    for (int i = 0; i < NR; i++) m[1][i] = m[0][i];
    m[1][10] = 32'hAA;
    for (int i = 0; i < NR; i++) rd($sformatf("copy_b1_r%0d", i), 2'd1, AW'(i));
    rd("no_restart_b0_r10", 2'd0, 5'd10);
    rd("no_restart_b0_r3", 2'd0, 5'd3);
    $display("copy: bank0 -> bank1 complete");

    // Out-of-range copy requests never start
    busy_cnt = 0; done_cnt = 0;
    copy_start = 1'b1; copy_src = 2'd0; copy_dst = 2'd3;
    tick();
    copy_src = 2'd3; copy_dst = 2'd0;
    tick();
    copy_start = 1'b0;
    for (int e = 0; e < 36; e++) begin
      if (copy_busy) busy_cnt++;
      if (copy_done) done_cnt++;
      tick();
    end
    check("bad_copy_busy", 32'(busy_cnt), 32'd0);
    check("bad_copy_done", 32'(done_cnt), 32'd0);
    $display("copy: out-of-range requests ignored");

    // Reset mid-copy after 8 copy edges: bank2 -> bank1
    copy_start = 1'b1; copy_src = 2'd2; copy_dst = 2'd1;
    tick();
    copy_start = 1'b0;
    for (int e = 1; e <= 8; e++) tick();
    check("midcopy_busy_before", {31'd0, copy_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("reset_busy_immediate", {31'd0, copy_busy}, 32'd0);
    check("reset_done_immediate", {31'd0, copy_done}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("after_reset_busy", {31'd0, copy_busy}, 32'd0);
    for (int i = 0; i < 8; i++) m[1][i] = m[2][i];
    for (int i = 0; i < NR; i++) rd($sformatf("partial_b1_r%0d", i), 2'd1, AW'(i));
    $display("reset: copy interrupted after 8 entries");

    // Index 0 behaviour (constant zero when the feature is enabled)
    wr(2'd0, 5'd0, 32'd5);
    rd("reg0_write", 2'd0, 5'd0);
    $display("reg0: write 5 to bank0 reg0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
